exu_gpr_wr_arb: RTL
===================

EXU_GPR_WR_ARB -- requirements
Module: exu_gpr_wr_arb

Interface
REQ-001 Parameter XLEN, default 32, sets the GPR data width and equals `RV_XLEN.
REQ-002 Parameter AW, default 5, sets the GPR address width and equals `RV_GPR_AW.
REQ-003 Parameter LQ_DEPTH, default 2, sets the load-return queue depth; legal values are 2 to 8.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-006 Port alu_vld, input, 1 bit: the ALU handler presents a write-back.
REQ-007 Port alu_rdy, output, 1 bit: the arbiter accepts the ALU write-back this cycle.
REQ-008 Port alu_addr, input, AW bits: ALU destination register.
REQ-009 Port alu_data, input, XLEN bits: ALU result.
REQ-010 Port lsu_vld, input, 1 bit: load return; it cannot be back-pressured.
REQ-011 Port lsu_addr, input, AW bits: load destination register.
REQ-012 Port lsu_data, input, XLEN bits: load data.
REQ-013 Port gpr_wen, output, 1 bit: GPR write enable.
REQ-014 Port gpr_waddr, output, AW bits: GPR write address.
REQ-015 Port gpr_wdata, output, XLEN bits: GPR write data.
REQ-016 Port qry_addr, input, AW bits: scoreboard query address.
REQ-017 Port qry_busy, output, 1 bit: a write to qry_addr is pending inside the block.
REQ-018 Port lq_cnt, output, clog2(LQ_DEPTH+1) bits: current load-queue occupancy.

Function
REQ-019 The block holds one FIFO load queue (LQ) of LQ_DEPTH {addr, data} entries and one registered output stage {gpr_wen, gpr_waddr, gpr_wdata}.
REQ-020 On lsu_vld=1 with lsu_addr!=0, the block pushes {lsu_addr, lsu_data} into the LQ at the clock edge; on lsu_vld=1 with lsu_addr=0, it drops the return silently.
REQ-021 Arbitration is evaluated each cycle between the ALU (alu_vld) and the LQ head (lq_cnt!=0), as follows.
  - LQ full (lq_cnt==LQ_DEPTH): the LQ head wins.
  - Otherwise: the ALU has strict priority.
REQ-022 alu_rdy = (lq_cnt != LQ_DEPTH); alu_rdy depends only on state, never on alu_vld.
REQ-023 An ALU handshake (alu_vld && alu_rdy) or an LQ pop loads the winner into the output stage; gpr_wen=1 on the following cycle for exactly one cycle unless the winner's addr is 0.
REQ-024 When no transfer occurs in a cycle, gpr_wen=0 on the next cycle and gpr_waddr/gpr_wdata hold their previous values.
REQ-025 ALU latency is 1 cycle (handshake at t, gpr_wen at t+1); minimum LSU latency is 2 cycles (push at t, pop at t+1, gpr_wen at t+2).
REQ-026 Push and pop in the same cycle leave lq_cnt unchanged; a push into a full LQ is legal because a full LQ always pops that cycle, so the LQ never overflows.
REQ-027 LQ pointers wrap modulo LQ_DEPTH; entries leave in arrival order.
REQ-028 qry_busy=1 in either of these cases, and qry_busy is combinational:
  - qry_addr!=0 and it matches any valid LQ entry;
  - qry_addr!=0 and it matches the output stage while gpr_wen=1.
REQ-029 qry_busy does not include the current-cycle alu_addr or lsu_addr.
REQ-030 Writes to the same register from ALU and LSU retire in grant order; the block performs no write merging.
REQ-031 The block contains no combinational path from any input to alu_rdy, gpr_wen, gpr_waddr, gpr_wdata or lq_cnt.

Reset
REQ-032 While rst_n=0, the block holds gpr_wen=0, gpr_waddr=0, gpr_wdata=0, lq_cnt=0 and LQ pointers at 0.
REQ-033 While rst_n=0, alu_rdy=1, and qry_busy=0 for every qry_addr.
REQ-034 Reset asserted mid-operation discards all queued and in-flight write-backs; none reaches gpr_wen after reset release.
REQ-035 The first clock edge after rst_n rises is a normal operating cycle.

Verification
REQ-036 ALU-only: alu_vld=1, alu_addr=5, alu_data=0x1234 at cycle t -> at t+1 gpr_wen=1, gpr_waddr=5, gpr_wdata=0x1234; at t+2 gpr_wen=0.
REQ-037 Contention: ALU valid every cycle; LSU pushes addr 7 and addr 8 on consecutive cycles -> the ALU wins until lq_cnt=2, that cycle alu_rdy=0, and addr 7 is written before addr 8.
REQ-038 x0 filtering: lsu_addr=0 -> lq_cnt stays 0; ALU handshake with alu_addr=0 -> alu_rdy=1 and gpr_wen stays 0.
REQ-039 Full with simultaneous push: LQ full (2 entries) and lsu_vld=1 -> head pops, new entry pushes, lq_cnt stays 2, and no entry is lost over the following cycles.
REQ-040 Scoreboard: LQ holds addr 9 -> qry_addr=9 gives qry_busy=1 and qry_addr=0 gives qry_busy=0; after addr 9's gpr_wen cycle, qry_busy=0.
REQ-041 Reset mid-queue: lq_cnt=2, then rst_n pulsed low asynchronously between clock edges -> gpr_wen=0 and lq_cnt=0 immediately, and no stale writes appear after release.

Source files
------------

// File: rtl/exu_gpr_wr_arb.sv
// GPR write-back arbiter: merges ALU results with a small FIFO of load returns
// into a single registered GPR write port, with a pending-write query for hazard checks.
module exu_gpr_wr_arb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned LQ_DEPTH = 2,
  localparam int unsigned CW      = $clog2(LQ_DEPTH + 1),
  localparam int unsigned PW      = $clog2(LQ_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_vld,
  output logic            alu_rdy,
  input  logic [AW-1:0]   alu_addr,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_vld,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [XLEN-1:0] lsu_data,
  output logic            gpr_wen,
  output logic [AW-1:0]   gpr_waddr,
  output logic [XLEN-1:0] gpr_wdata,
  input  logic [AW-1:0]   qry_addr,
  output logic            qry_busy,
  output logic [CW-1:0]   lq_cnt
);

  logic [AW-1:0]   lq_addr_q [LQ_DEPTH];
  logic [XLEN-1:0] lq_data_q [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] lq_vld_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            lq_full, lq_empty, push, pop, alu_go, xfer;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LQ_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    lq_full  = (cnt_q == CW'(LQ_DEPTH));
    lq_empty = (cnt_q == '0);
    alu_rdy  = !lq_full;
    push     = lsu_vld && (lsu_addr != '0);
    // A full queue must drain so that a same-cycle load return can never overflow it.
    pop      = lq_full || (!alu_vld && !lq_empty);
    alu_go   = alu_vld && !lq_full;
    xfer     = pop || alu_go;
    win_addr = pop ? lq_addr_q[rd_ptr_q] : alu_addr;
    win_data = pop ? lq_data_q[rd_ptr_q] : alu_data;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    qry_busy = 1'b0;
    if (qry_addr != '0) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        if (lq_vld_q[i] && (lq_addr_q[i] == qry_addr)) qry_busy = 1'b1;
      end
      if (gpr_wen && (gpr_waddr == qry_addr)) qry_busy = 1'b1;
    end
  end

  assign lq_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_addr_q[i] <= '0;
        lq_data_q[i] <= '0;
      end
      lq_vld_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else begin
      if (pop) begin
        lq_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q           <= ptr_inc(rd_ptr_q);
      end
      // Push after pop: when full both pointers alias and the new entry must stay valid.
      if (push) begin
        lq_addr_q[wr_ptr_q] <= lsu_addr;
        lq_data_q[wr_ptr_q] <= lsu_data;
        lq_vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      cnt_q <= cnt_d;
      if (xfer) begin
        gpr_wen   <= (win_addr != '0);
        gpr_waddr <= win_addr;
        gpr_wdata <= win_data;
      end else begin
        gpr_wen <= 1'b0;
      end
    end
  end

endmodule
